// File: rtl/lut_input_packer.sv
// Packs a stream of FEAT_W-bit input features into one N_FEAT-feature word for
// LUT layer 0, with a second buffer so the next frame assembles while a word waits.
module lut_input_packer #(
   parameter  int FEAT_W = 4,
   parameter  int N_FEAT = 16,
   localparam int OUT_W  = FEAT_W * N_FEAT,
   localparam int IDX_W  = (N_FEAT > 1) ? $clog2(N_FEAT) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   // Both ports use strict valid/ready: a transfer happens on a rising edge where
   // valid && ready; valid, data and last never depend on ready, and once
   // m_valid is raised m_valid/m_data stay stable until the word is taken.
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [FEAT_W-1:0] s_data,
   input  logic              s_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [OUT_W-1:0]  m_data,
   output logic              frame_err,
   // {asm_full, state (1 = DROP), idx}
   output logic [IDX_W+1:0]  dbg_state
);

   typedef enum logic [0:0] {
      FILL = 1'b0,
      DROP = 1'b1
   } state_t;

   state_t             r_state;
   logic [IDX_W-1:0]   r_idx;
   logic [OUT_W-1:0]   r_asm;
   logic               r_asm_full;
   logic [OUT_W-1:0]   r_m_data;
   logic               r_m_valid;
   logic               r_frame_err;

   logic               w_accept;
   logic               w_consume;
   logic               w_last_idx;
   logic               w_complete;
   logic               w_out_free;
   logic [OUT_W-1:0]   w_new_word;

   assign s_ready    = !r_asm_full;
   assign m_valid    = r_m_valid;
   assign m_data     = r_m_data;
   assign frame_err  = r_frame_err;
   assign dbg_state  = {r_asm_full, r_state, r_idx};

   assign w_accept   = s_valid && s_ready;
   assign w_consume  = r_m_valid && m_ready;
   assign w_last_idx = (r_idx == IDX_W'(N_FEAT - 1));
   assign w_complete = w_accept && (r_state == FILL) && w_last_idx;
   assign w_out_free = !r_m_valid || m_ready;

   // Assembly word with the current beat merged into its slice; used both for
   // ordinary slice writes and for the completed word on the final beat.
   always_comb begin
      w_new_word = r_asm;
      for (int k = 0; k < N_FEAT; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_new_word[k*FEAT_W +: FEAT_W] = s_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= FILL;
         r_idx       <= '0;
         r_asm       <= '0;
         r_asm_full  <= 1'b0;
         r_m_data    <= '0;
         r_m_valid   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;

         if (w_accept) begin
            case (r_state)
               FILL: begin
                  if (!w_last_idx) begin
                     if (s_last) begin
                        r_frame_err <= 1'b1;
                        r_idx       <= '0;
                     end else begin
                        r_asm <= w_new_word;
                        r_idx <= r_idx + 1'b1;
                     end
                  end else begin
                     r_idx <= '0;
                     if (!s_last) begin
                        // Over-long frame: the first N_FEAT features still go out,
                        // the remainder is swallowed until s_last.
                        r_frame_err <= 1'b1;
                        r_state     <= DROP;
                     end
                  end
               end
               DROP: begin
                  if (s_last) begin
                     r_state <= FILL;
                     r_idx   <= '0;
                  end
               end
               default: begin
                  r_state <= FILL;
                  r_idx   <= '0;
               end
            endcase
         end

         if (w_complete && w_out_free) begin
            r_m_data  <= w_new_word;
            r_m_valid <= 1'b1;
         end else if (w_complete) begin
            r_asm      <= w_new_word;
            r_asm_full <= 1'b1;
         end else if (w_consume) begin
            if (r_asm_full) begin
               r_m_data   <= r_asm;
               r_asm_full <= 1'b0;
            end else begin
               r_m_valid <= 1'b0;
            end
         end
      end
   end

endmodule
